uart_rx_ctrl: RTL and testbench

UART receive front-end and frame controller that sits directly upstream of the stop-bit checker. It oversamples rx_in and majority-votes each bit. It tracks edge and bit position and sequences START/DATA/PARITY/STOP. It drives sampled_bit, bit_cnt and stp_chk_en to the stop checker, consumes the checker's registered stp_err, and delivers the deserialised byte with data_valid and error flags to the ALU-side logic.

---
 rtl/uart_rx_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive front-end: oversampled majority-vote bit recovery and START/DATA/PARITY/STOP
// sequencing, handing stop-bit checking to an external registered checker.
module uart_rx_ctrl #(
    parameter int sampling_bits = 6,
    parameter int bit_cnt_w     = 4,
    parameter int frame_data    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_in,
    input  logic [sampling_bits-1:0] prescale,
    input  logic                     par_en,
    input  logic                     par_typ,
    input  logic                     stp_err,
    output logic                     sampled_bit,
    output logic [bit_cnt_w-1:0]     bit_cnt,
    output logic                     stp_chk_en,
    output logic [frame_data-1:0]    p_data,
    output logic                     data_valid,
    output logic                     par_err,
    output logic                     frame_err,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [sampling_bits-1:0] E_ZERO = sampling_bits'(0);
    localparam logic [sampling_bits-1:0] E_ONE  = sampling_bits'(1);
    localparam logic [sampling_bits-1:0] E_TWO  = sampling_bits'(2);
    localparam logic [sampling_bits-1:0] E_THR  = sampling_bits'(3);
    localparam logic [sampling_bits-1:0] MIN_P  = sampling_bits'(8);
    localparam logic [bit_cnt_w-1:0]     BC_ZERO = bit_cnt_w'(0);
    localparam logic [bit_cnt_w-1:0]     BC_ONE  = bit_cnt_w'(1);
    localparam logic [bit_cnt_w-1:0]     BC_LAST = bit_cnt_w'(frame_data);
    localparam logic [frame_data-1:0]    D_ZERO  = frame_data'(0);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_f(input logic [frame_data-1:0] d);
        return ^d;
    endfunction

    state_t                   state_q;
    logic [sampling_bits-1:0] p_q;
    logic                     par_en_q;
    logic                     par_typ_q;
    logic [sampling_bits-1:0] edge_q;
    logic [bit_cnt_w-1:0]     bit_cnt_q;
    logic [frame_data-1:0]    shift_q;
    logic                     cap0_q;
    logic                     cap1_q;
    logic                     sampled_bit_q;
    logic                     stp_chk_en_q;
    logic [frame_data-1:0]    p_data_q;
    logic                     data_valid_q;
    logic                     par_err_q;
    logic                     frame_err_q;
    logic                     busy_q;

    logic [sampling_bits-1:0] eff_p_s;
    logic [sampling_bits-1:0] mid_s;
    logic                     last_s;
    logic                     frame_err_now_s;

    assign eff_p_s = (prescale < MIN_P) ? MIN_P : prescale;
    assign mid_s   = p_q >> 1;
    assign last_s  = (edge_q == (p_q - E_ONE));
    // With P=8 the stop-error latch point coincides with the decision point, so look through.
    assign frame_err_now_s = (edge_q == (mid_s + E_THR)) ? stp_err : frame_err_q;

    // Frame sequencer, oversampling counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            p_q           <= E_ZERO;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            edge_q        <= E_ZERO;
            bit_cnt_q     <= BC_ZERO;
            shift_q       <= D_ZERO;
            cap0_q        <= 1'b1;
            cap1_q        <= 1'b1;
            sampled_bit_q <= 1'b1;
            stp_chk_en_q  <= 1'b0;
            p_data_q      <= D_ZERO;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            stp_chk_en_q <= 1'b0;
            data_valid_q <= 1'b0;

            if (state_q != S_IDLE) begin
                edge_q <= last_s ? E_ZERO : (edge_q + E_ONE);
                if (edge_q == (mid_s - E_ONE)) cap0_q <= rx_in;
                if (edge_q == mid_s)           cap1_q <= rx_in;
                if (edge_q == (mid_s + E_ONE)) sampled_bit_q <= majority3(cap0_q, cap1_q, rx_in);
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_in) begin
                        state_q     <= S_START;
                        edge_q      <= E_ONE;
                        bit_cnt_q   <= BC_ZERO;
                        p_q         <= eff_p_s;
                        par_en_q    <= par_en;
                        par_typ_q   <= par_typ;
                        par_err_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_START: begin
                    if (last_s) begin
                        if (sampled_bit_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= BC_ONE;
                        end
                    end
                end
                S_DATA: begin
                    if (last_s) begin
                        shift_q   <= {sampled_bit_q, shift_q[frame_data-1:1]};
                        bit_cnt_q <= bit_cnt_q + BC_ONE;
                        if (bit_cnt_q == BC_LAST) begin
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (last_s) begin
                        par_err_q <= (parity_f(shift_q) ^ par_typ_q) != sampled_bit_q;
                        bit_cnt_q <= bit_cnt_q + BC_ONE;
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (edge_q == (mid_s + E_ONE)) stp_chk_en_q <= 1'b1;
                    if (edge_q == (mid_s + E_THR)) frame_err_q  <= stp_err;
                    if (last_s) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= BC_ZERO;
                        if (!frame_err_now_s && !par_err_q) begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    edge_q  <= E_TWO - E_TWO;
                end
            endcase
        end
    end

    assign sampled_bit = sampled_bit_q;
    assign bit_cnt     = bit_cnt_q;
    assign stp_chk_en  = stp_chk_en_q;
    assign p_data      = p_data_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a registered stop-bit checker model attached.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stp_err;
    logic       sampled_bit;
    logic [3:0] bit_cnt;
    logic       stp_chk_en;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       frame_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int   dv_cyc_q[$];
    int   dv_dat_q[$];
    int   chk_bc_q[$];
    int   err_q[$];
    logic chk_prev = 1'b0;
    logic [3:0] max_bc = 4'd0;

    uart_rx_ctrl #(.sampling_bits(6), .bit_cnt_w(4), .frame_data(8)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .stp_err(stp_err),
        .sampled_bit(sampled_bit), .bit_cnt(bit_cnt), .stp_chk_en(stp_chk_en),
        .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stop checker model: flags a low stop bit one cycle after the strobe.
    always @(posedge clk) begin
        if (rst) stp_err <= 1'b0;
        else     stp_err <= stp_chk_en & ~sampled_bit;
    end

    // Event recorder, sampled on the falling edge.
    always @(negedge clk) begin
        chk_prev <= stp_chk_en;
        if (chk_prev) err_q.push_back(int'(stp_err));
        if (data_valid) begin
            dv_cyc_q.push_back(cyc);
            dv_dat_q.push_back(int'(p_data));
        end
        if (stp_chk_en) chk_bc_q.push_back(int'(bit_cnt));
        if (bit_cnt > max_bc) max_bc <= bit_cnt;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_cycles(input logic b, input int n);
        rx_in = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one frame; glitch_bit/glitch_off pull rx low for one cycle at that bit/edge.
    task automatic send_frame(input logic [7:0] data, input int p, input logic use_par,
                              input logic par_bit, input logic stop_bit,
                              input int glitch_bit, input int glitch_off, output int start_cyc);
        logic bits [0:10];
        int   nbits;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        bits[9]  = use_par ? par_bit : stop_bit;
        bits[10] = stop_bit;
        nbits = use_par ? 11 : 10;
        start_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            for (int o = 0; o < p; o++) begin
                rx_in = (i == glitch_bit && o == glitch_off) ? 1'b0 : bits[i];
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2, bdv, bchk, berr;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_bitcnt", bit_cnt, 0);
        check_eq("rst_sampled", sampled_bit, 1);
        check_eq("rst_pdata", p_data, 0);
        check_eq("rst_flags", {data_valid, par_err, frame_err, stp_chk_en}, 0);

        // Test 1: back-to-back 0xA5, 0x3C at P=8 without parity.
        prescale = 6'd8; par_en = 1'b0;
        drive_cycles(1'b1, 5);
        bdv = dv_cyc_q.size(); bchk = chk_bc_q.size(); berr = err_q.size();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, -1, s1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, -1, -1, s2);
        drive_cycles(1'b1, 10);
        check_eq("t1_dv_count", dv_cyc_q.size() - bdv, 2);
        check_eq("t1_lat0", dv_cyc_q[bdv] - s1, 80);
        check_eq("t1_lat1", dv_cyc_q[bdv+1] - s2, 80);
        check_eq("t1_data0", dv_dat_q[bdv], 32'hA5);
        check_eq("t1_data1", dv_dat_q[bdv+1], 32'h3C);
        check_eq("t1_chk_count", chk_bc_q.size() - bchk, 2);
        check_eq("t1_chk_bc0", chk_bc_q[bchk], 9);
        check_eq("t1_chk_bc1", chk_bc_q[bchk+1], 9);
        check_eq("t1_stperr", err_q[berr], 0);
        check_eq("t1_frame_err", frame_err, 0);

        // Test 2: P=16 even parity, good then bad parity bit.
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        bdv = dv_cyc_q.size(); bchk = chk_bc_q.size();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1, -1, s1);
        drive_cycles(1'b1, 4);
        check_eq("t2_dv_count", dv_cyc_q.size() - bdv, 1);
        check_eq("t2_lat", dv_cyc_q[bdv] - s1, 176);
        check_eq("t2_data", dv_dat_q[bdv], 32'h3C);
        check_eq("t2_par_err_ok", par_err, 0);
        check_eq("t2_chk_bc", chk_bc_q[bchk], 10);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1, -1, s1);
        drive_cycles(1'b1, 4);
        check_eq("t2_bad_dv", dv_cyc_q.size() - bdv, 1);
        check_eq("t2_par_err_bad", par_err, 1);
        check_eq("t2_pdata_hold", p_data, 32'h3C);
        check_eq("t2_frame_err", frame_err, 0);

        // Test 3: prescale 3 (behaves as 8), stop bit low.
        prescale = 6'd3; par_en = 1'b0;
        bdv = dv_cyc_q.size(); berr = err_q.size();
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, -1, -1, s1);
        drive_cycles(1'b1, 20);
        check_eq("t3_stperr", err_q[berr], 1);
        check_eq("t3_frame_err", frame_err, 1);
        check_eq("t3_no_dv", dv_cyc_q.size() - bdv, 0);
        check_eq("t3_par_err", par_err, 0);
        check_eq("t3_pdata_hold", p_data, 32'h3C);

        // Test 4: 3-cycle glitch at P=16 returns to IDLE at the start decision point.
        prescale = 6'd16;
        bdv = dv_cyc_q.size(); bchk = chk_bc_q.size();
        drive_cycles(1'b0, 3);
        check_eq("t4_busy_start", busy, 1);
        check_eq("t4_ferr_cleared", frame_err, 0);
        drive_cycles(1'b1, 12);
        check_eq("t4_busy_pre", busy, 1);
        drive_cycles(1'b1, 1);
        check_eq("t4_busy_idle", busy, 0);
        check_eq("t4_bitcnt", bit_cnt, 0);
        drive_cycles(1'b1, 20);
        check_eq("t4_no_chk", chk_bc_q.size() - bchk, 0);
        check_eq("t4_no_dv", dv_cyc_q.size() - bdv, 0);

        // Test 5: single-cycle low at mid of data bit 3 is outvoted.
        par_en = 1'b0;
        bdv = dv_cyc_q.size();
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1, 3, 8, s1);
        drive_cycles(1'b1, 4);
        check_eq("t5_dv_count", dv_cyc_q.size() - bdv, 1);
        check_eq("t5_data", p_data, 32'hFF);

        // Test 6: reset in the middle of data bit 4, then a clean 0x81.
        prescale = 6'd8;
        drive_cycles(1'b0, 8);
        drive_cycles(1'b1, 24);
        drive_cycles(1'b0, 4);
        rst = 1'b1;
        rx_in = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_busy", busy, 0);
        check_eq("t6_bitcnt", bit_cnt, 0);
        check_eq("t6_sampled", sampled_bit, 1);
        check_eq("t6_pdata", p_data, 0);
        check_eq("t6_flags", {data_valid, par_err, frame_err, stp_chk_en}, 0);
        rst = 1'b0;
        drive_cycles(1'b1, 10);
        bdv = dv_cyc_q.size();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1, -1, s1);
        drive_cycles(1'b1, 4);
        check_eq("t6_dv_count", dv_cyc_q.size() - bdv, 1);
        check_eq("t6_lat", dv_cyc_q[bdv] - s1, 80);
        check_eq("t6_data", p_data, 32'h81);

        check_eq("max_bitcnt", max_bc, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
